// File: rtl/cpu_state_dump_if.sv
// -----------------------------------------------------------------------------
// cpu_state_dump_if
//   Valid/ready word stream carrying the architectural-state dump from the
//   cpu_state_dump responder to the bench or host link.
//
//   Signals:
//     out_valid  stream word valid (producer)
//     out_ready  consumer accepts the word (consumer)
//     out_tag    8-bit word tag: 0x00 cycle, 0x01 PC, 0x02 ALU, 0x10+i reg i
//     out_data   DATA_W-bit word payload
//
//   Modports:
//     master  the dump responder (drives valid/tag/data, samples ready)
//     slave   the consumer (samples valid/tag/data, drives ready)
// -----------------------------------------------------------------------------
interface cpu_state_dump_if #(
  parameter int DATA_W = 32
) ();

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_tag;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_tag,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_tag,
    input  out_data,
    output out_ready
  );

endinterface : cpu_state_dump_if

// File: rtl/cpu_state_dump.sv
// -----------------------------------------------------------------------------
// cpu_state_dump
//   Debug responder that freezes the core and streams its architectural
//   state. A dump is triggered on demand (dbg_start) or when the idle-cycle
//   counter reaches stop_cycle. The block halts the pipeline, snapshots the
//   cycle count, PC and EX-stage ALU result, then reads every register-file
//   entry through the debug read port. Words leave as a tagged stream:
//   cycle, PC, ALU, R0..R(NUM_REGS-1).
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset
//     stop_cycle   auto-trigger cycle number (0 disables auto-trigger)
//     dbg_start    on-demand request, only honoured while idle
//     pc_in        program counter from the core
//     alu_out_in   EX-stage ALU result from the core
//     halt_req     stall request to the core
//     halt_ack     core frozen, register file no longer written
//     rf_rd_addr   register-file debug read address
//     rf_rd_data   read data, valid one cycle after the address
//     out_if       stream of tagged words (master side)
//     busy         high whenever a dump is in progress
//     done         one-cycle pulse after the last word is accepted
//
//   Parameters: NUM_REGS entries dumped, DATA_W data width, IDX_W index
//   width (2**IDX_W must cover NUM_REGS).
// -----------------------------------------------------------------------------
module cpu_state_dump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             stop_cycle,
  input  logic                    dbg_start,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [DATA_W-1:0]       alu_out_in,
  output logic                    halt_req,
  input  logic                    halt_ack,
  output logic [IDX_W-1:0]        rf_rd_addr,
  input  logic [DATA_W-1:0]       rf_rd_data,
  cpu_state_dump_if.master        out_if,
  output logic                    busy,
  output logic                    done
);

  localparam logic [7:0] TAG_CYCLE    = 8'h00;
  localparam logic [7:0] TAG_PC       = 8'h01;
  localparam logic [7:0] TAG_ALU      = 8'h02;
  localparam logic [7:0] TAG_REG_BASE = 8'h10;

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,   // counting cycles, watching for a trigger
    S_HALT,   // halt_req raised, waiting for the core to freeze
    S_HDR,    // streaming the three snapshot words
    S_RDREQ,  // register address on the debug read port
    S_RDCAP,  // read data arrives, load it into the output register
    S_EMIT,   // register word on the stream, waiting for the handshake
    S_DONE    // done pulse, release the core
  } state_e;

  state_e            r_state;
  logic [31:0]       r_cycle_cnt;
  logic [31:0]       r_snap_cycle;
  logic [DATA_W-1:0] r_snap_pc;
  logic [DATA_W-1:0] r_snap_alu;
  logic [1:0]        r_hdr_idx;
  logic [IDX_W-1:0]  r_reg_idx;
  logic              r_halt_req;
  logic              r_out_valid;
  logic [7:0]        r_out_tag;
  logic [DATA_W-1:0] r_out_data;
  logic              r_busy;
  logic              r_done;

  logic w_trigger;
  logic w_handshake;

  // Both trigger sources share one OR, so a simultaneous dbg_start and
  // stop_cycle match can only ever start a single dump.
  assign w_trigger   = dbg_start || ((stop_cycle != 32'd0) && (r_cycle_cnt == stop_cycle));
  assign w_handshake = r_out_valid && out_if.out_ready;

  // NOTE: the reset test lives inside the clocked block, so reset is
  // synchronous; every register (outputs included) is cleared on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= 32'd1;
      r_snap_cycle <= '0;
      r_snap_pc    <= '0;
      r_snap_alu   <= '0;
      r_hdr_idx    <= '0;
      r_reg_idx    <= '0;
      r_halt_req   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_tag    <= '0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the register values from before this edge regardless of order.
      unique case (r_state)
        S_IDLE: begin
          // Counter runs every idle cycle, including the trigger cycle; that
          // increment is the +1 it resumes with once the dump finishes.
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          if (w_trigger) begin
            r_snap_cycle <= r_cycle_cnt;
            r_snap_pc    <= pc_in;
            r_snap_alu   <= alu_out_in;
            r_halt_req   <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_HALT;
          end
        end

        S_HALT: begin
          if (halt_ack) begin
            r_hdr_idx   <= 2'd0;
            r_out_valid <= 1'b1;
            r_out_tag   <= TAG_CYCLE;
            r_out_data  <= DATA_W'(r_snap_cycle);
            r_state     <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_handshake) begin
            unique case (r_hdr_idx)
              2'd0: begin
                r_hdr_idx  <= 2'd1;
                r_out_tag  <= TAG_PC;
                r_out_data <= r_snap_pc;
              end
              2'd1: begin
                r_hdr_idx  <= 2'd2;
                r_out_tag  <= TAG_ALU;
                r_out_data <= r_snap_alu;
              end
              default: begin
                r_out_valid <= 1'b0;
                r_reg_idx   <= '0;
                r_state     <= S_RDREQ;
              end
            endcase
          end
        end

        // r_reg_idx doubles as the read address, so it is already on the
        // port for this whole cycle.
        S_RDREQ: r_state <= S_RDCAP;

        S_RDCAP: begin
          r_out_valid <= 1'b1;
          r_out_tag   <= TAG_REG_BASE + 8'(r_reg_idx);
          r_out_data  <= rf_rd_data;
          r_state     <= S_EMIT;
        end

        S_EMIT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (r_reg_idx == LAST_REG) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_reg_idx <= r_reg_idx + IDX_W'(1);
              r_state   <= S_RDREQ;
            end
          end
        end

        S_DONE: begin
          r_done     <= 1'b0;
          r_halt_req <= 1'b0;
          r_busy     <= 1'b0;
          r_reg_idx  <= '0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign halt_req         = r_halt_req;
  assign rf_rd_addr       = r_reg_idx;
  assign busy             = r_busy;
  assign done             = r_done;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_tag   = r_out_tag;
  assign out_if.out_data  = r_out_data;

endmodule : cpu_state_dump

// File: tb/tb_cpu_state_dump.sv
// -----------------------------------------------------------------------------
// tb_cpu_state_dump
//   Bench for cpu_state_dump. A table of dump scenarios (trigger source,
//   consumer readiness, core halt behaviour, expected cycle word) is applied
//   in a loop, each followed by an on-demand dump whose cycle word tests the
//   frozen/resumed counter. Randomized dumps, a mid-dump reset and a long
//   disabled run follow. The expected stream is built from the snapshot
//   values and the register contents; cycle numbers come from counting bench
//   cycles since reset release.
// -----------------------------------------------------------------------------
module tb_cpu_state_dump;

  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 5;
  localparam int DUMP_WORDS = 3 + NUM_REGS;

  typedef struct packed {
    logic [7:0]        tag;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef struct {
    logic [31:0] stop;        // stop_cycle programmed at reset
    int          dbg_at;      // bench cycle of the dbg_start pulse, -1 none
    int          ready_mode;  // 0 always ready, 1 toggling, 2 random
    int          ack_d;       // extra cycles before halt_ack rises
    bit          ack_pulse;   // halt_ack high for a single cycle only
    bit          mid_trig;    // fire both trigger sources during the dump
    logic [31:0] exp_cycle;   // expected cycle word
    int          exp_words;   // expected stream length
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       stop_cycle = '0;
  logic              dbg_start = 1'b0;
  logic [DATA_W-1:0] pc_in = '0;
  logic [DATA_W-1:0] alu_out_in = '0;
  logic              halt_req;
  logic              halt_ack = 1'b0;
  logic [IDX_W-1:0]  rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              busy;
  logic              done;

  cpu_state_dump_if #(.DATA_W(DATA_W)) sif ();

  cpu_state_dump #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stop_cycle (stop_cycle),
    .dbg_start  (dbg_start),
    .pc_in      (pc_in),
    .alu_out_in (alu_out_in),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_if     (sif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Core register file with a registered debug read port.
  logic [DATA_W-1:0] core_regs [NUM_REGS];
  always @(posedge clk) rf_rd_data <= core_regs[rf_rd_addr];

  int    n_vec  = 0;
  int    n_miss = 0;

  word_t got_q[$];
  int    t;             // bench cycle index; cycle 1 is the first out of reset
  int    dbg_at, mid_at;
  logic [31:0] mid_stop;
  int    ready_mode, ack_d;
  bit    ack_pulse;
  int    hr_cnt;
  bit    prev_ack, stalled, done_prev;
  word_t stall_word;
  int    done_cnt, done_t, trig_t, first_valid_t, ack_rise_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pc_of(input int c);
    return DATA_W'(25 * c);
  endfunction

  function automatic logic [DATA_W-1:0] alu_of(input int c);
    return DATA_W'(32'h5A5A_0000 ^ (c * 977));
  endfunction

  // One clock cycle: drive inputs for cycle t, record any handshake, clock,
  // then sample the registered outputs of the new cycle.
  task automatic cyc();
    pc_in      = pc_of(t);
    alu_out_in = alu_of(t);
    dbg_start  = (t == dbg_at) || (t == mid_at);
    if (t == mid_at) stop_cycle = mid_stop;
    case (ready_mode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = (t % 2 == 0);
      default: sif.out_ready = 1'($urandom_range(0, 1));
    endcase
    halt_ack = ack_pulse ? (hr_cnt == ack_d + 1) : (hr_cnt > ack_d);
    if (halt_ack && !prev_ack && ack_rise_t < 0) ack_rise_t = t;
    prev_ack = halt_ack;

    if (stalled)
      check("stall_hold", {sif.out_valid, sif.out_tag, sif.out_data}, {1'b1, stall_word});
    stalled    = sif.out_valid && !sif.out_ready;
    stall_word = {sif.out_tag, sif.out_data};
    if (rst_n && sif.out_valid && sif.out_ready)
      got_q.push_back({sif.out_tag, sif.out_data});

    @(posedge clk);
    #1;
    t++;
    if (done_prev) check("halt_req_after_done", halt_req, 1'b0);
    done_prev = done;
    if (done) begin
      done_cnt++;
      done_t = t;
    end
    hr_cnt = halt_req ? hr_cnt + 1 : 0;
    if (halt_req && trig_t < 0) trig_t = t;
    if (sif.out_valid && first_valid_t < 0) first_valid_t = t;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, ".halt_req"},   halt_req,      1'b0);
    check({nm, ".rf_rd_addr"}, rf_rd_addr,    '0);
    check({nm, ".out_valid"},  sif.out_valid, 1'b0);
    check({nm, ".out_tag"},    sif.out_tag,   '0);
    check({nm, ".out_data"},   sif.out_data,  '0);
    check({nm, ".busy"},       busy,          1'b0);
    check({nm, ".done"},       done,          1'b0);
  endtask

  task automatic clear_dump_state();
    got_q.delete();
    done_cnt      = 0;
    done_t        = -1;
    trig_t        = -1;
    first_valid_t = -1;
    ack_rise_t    = -1;
  endtask

  task automatic do_reset(input bit check_outs);
    rst_n  = 1'b0;
    dbg_at = -1;
    mid_at = -1;
    cyc();
    cyc();
    if (check_outs) check_idle_outputs("reset");
    rst_n     = 1'b1;
    t         = 1;
    stalled   = 1'b0;
    done_prev = 1'b0;
    hr_cnt    = 0;
    prev_ack  = 1'b0;
  endtask

  // Runs until a done pulse (bounded), then four more cycles to expose a
  // second pulse or a late halt_req.
  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc();
      n++;
    end
    if (done_cnt != 0)
      for (int i = 0; i < 4; i++) cyc();
  endtask

  // Expected stream: snapshot of the trigger cycle's inputs, then every
  // register in index order.
  task automatic check_dump(input string nm, input logic [31:0] exp_cycle,
                            input int trig_cycle, input int exp_words,
                            input bit timed, input int ackd);
    word_t exp_q[$];
    exp_q.push_back({8'h00, DATA_W'(exp_cycle)});
    exp_q.push_back({8'h01, pc_of(trig_cycle)});
    exp_q.push_back({8'h02, alu_of(trig_cycle)});
    for (int i = 0; i < NUM_REGS; i++)
      exp_q.push_back({8'(8'h10 + i), core_regs[i]});

    check({nm, ".words"}, got_q.size(), exp_words);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.word%0d", nm, i), got_q[i], exp_q[i]);
    check({nm, ".done_pulses"}, done_cnt, 1);
    check({nm, ".halt_latency"}, trig_t - trig_cycle, 1);
    check({nm, ".ack_to_valid"}, first_valid_t - ack_rise_t, 1);
    if (timed)
      check({nm, ".trigger_to_done"}, done_t - trig_cycle + 1,
            1 + (1 + ackd) + 3 + 3 * NUM_REGS + 1);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t        v;
    int          trig_c, j, bad_h, bad_v;
    logic [31:0] exp_c;

    vecs[0] = '{32'd8,  -1, 0,  1, 1'b0, 1'b0, 32'd8,  DUMP_WORDS}; // auto-trigger
    vecs[1] = '{32'd3,  -1, 0,  0, 1'b0, 1'b0, 32'd3,  DUMP_WORDS}; // ack already high
    vecs[2] = '{32'd5,  -1, 1,  1, 1'b0, 1'b0, 32'd5,  DUMP_WORDS}; // backpressure
    vecs[3] = '{32'd6,  -1, 0, 20, 1'b0, 1'b0, 32'd6,  DUMP_WORDS}; // long halt wait
    vecs[4] = '{32'd0,  13, 2,  2, 1'b1, 1'b0, 32'd13, DUMP_WORDS}; // on demand, ack pulse
    vecs[5] = '{32'd10, 10, 0,  1, 1'b0, 1'b1, 32'd10, DUMP_WORDS}; // both sources + ignored

    ready_mode = 0; ack_d = 0; ack_pulse = 1'b0; mid_stop = '0;
    t = 0; hr_cnt = 0; prev_ack = 1'b0; stalled = 1'b0; done_prev = 1'b0;
    stall_word = '0; dbg_at = -1; mid_at = -1;
    clear_dump_state();

    for (int r = 0; r < 6; r++) begin
      v = vecs[r];
      for (int i = 0; i < NUM_REGS; i++) core_regs[i] = $urandom();
      if (r == 0) begin
        core_regs[0] = 32'd16; core_regs[1] = 32'd17;
        core_regs[2] = 32'd0;  core_regs[3] = 32'd17;
      end
      stop_cycle = v.stop;
      do_reset(r == 0);
      ready_mode = v.ready_mode;
      ack_d      = v.ack_d;
      ack_pulse  = v.ack_pulse;
      dbg_at     = v.dbg_at;
      trig_c     = (v.dbg_at >= 0) ? v.dbg_at : int'(v.stop);
      mid_at     = v.mid_trig ? trig_c + 8 : -1;
      mid_stop   = v.exp_cycle;
      clear_dump_state();
      run_until_done(3000);
      check_dump($sformatf("row%0d", r), v.exp_cycle, trig_c, v.exp_words,
                 (v.ready_mode == 0) && !v.ack_pulse, v.ack_d);

      // On-demand dump j idle cycles after done: counter resumed at snap+1.
      j      = $urandom_range(5, 15);
      dbg_at = done_t + 1 + j;
      mid_at = -1;
      clear_dump_state();
      run_until_done(3000);
      check_dump($sformatf("row%0d_resume", r), v.exp_cycle + 32'd1 + 32'(j),
                 dbg_at, DUMP_WORDS, 1'b0, ack_d);
    end

    // Randomized dumps straight out of reset: cycle word = trigger cycle.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NUM_REGS; i++) core_regs[i] = $urandom();
      trig_c = $urandom_range(2, 60);
      stop_cycle = (k % 2 == 0) ? 32'(trig_c) : 32'd0;
      do_reset(1'b0);
      dbg_at     = (k % 2 == 0) ? -1 : trig_c;
      ready_mode = 2;
      ack_d      = $urandom_range(0, 4);
      ack_pulse  = 1'($urandom_range(0, 1));
      clear_dump_state();
      run_until_done(3000);
      check_dump($sformatf("rand%0d", k), 32'(trig_c), trig_c, DUMP_WORDS, 1'b0, ack_d);
    end

    // Mid-dump reset after the 10th accepted word.
    stop_cycle = 32'd30;
    do_reset(1'b0);
    ready_mode = 0; ack_d = 1; ack_pulse = 1'b0;
    clear_dump_state();
    for (int n = 0; n < 500 && got_q.size() < 10; n++) cyc();
    check("midreset.words_before", got_q.size(), 10);
    rst_n = 1'b0;
    cyc();
    check_idle_outputs("midreset");
    rst_n = 1'b1; t = 1; stalled = 1'b0; done_prev = 1'b0; hr_cnt = 0; prev_ack = 1'b0;
    stop_cycle = 32'd4;
    clear_dump_state();
    run_until_done(3000);
    check_dump("after_reset", 32'd4, 4, DUMP_WORDS, 1'b1, 1);

    // Disabled: no trigger source for 1000 cycles.
    stop_cycle = 32'd0;
    do_reset(1'b0);
    ready_mode = 2;
    bad_h = 0; bad_v = 0;
    for (int n = 0; n < 1000; n++) begin
      cyc();
      if (halt_req) bad_h++;
      if (sif.out_valid) bad_v++;
    end
    check("disable.halt_req_cycles", bad_h, 0);
    check("disable.out_valid_cycles", bad_v, 0);

    // Counter keeps counting through a long idle stretch.
    exp_c  = 32'(t + 3);
    dbg_at = t + 3;
    ack_d  = 0;
    clear_dump_state();
    run_until_done(3000);
    check_dump("disable_then_dbg", exp_c, int'(exp_c), DUMP_WORDS, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_cpu_state_dump

// File: doc/cpu_state_dump.md
# cpu_state_dump

Debug responder that captures and streams the processor's architectural state so benches and the lab board can check it. It is the other end of the state-inspection interface. A bench or host requests a dump, either at a programmed cycle or on demand. The block halts the pipeline, snapshots the cycle count, PC and EX-stage ALU result, and reads every register-file entry through a dedicated read port. It emits the results as a tagged word stream under valid/ready flow control. It sits beside `Top`, between the core and the bench/host link.

## Interface
Parameters:
- `NUM_REGS`, 32: register-file entries dumped, indices 0..NUM_REGS-1.
- `DATA_W`, 32: width of PC, ALU result, register data and stream data.
- `IDX_W`, 5: register index width; must satisfy 2^IDX_W >= NUM_REGS.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stop_cycle` in 32: auto-trigger cycle number; 0 disables auto-trigger.
- `dbg_start` in 1: on-demand dump request, sampled in IDLE only.
- `pc_in` in DATA_W: current program counter from the core.
- `alu_out_in` in DATA_W: EX-stage ALU result from the core.
- `halt_req` out 1: stall request to the core.
- `halt_ack` in 1: core is frozen, with no further register-file writes.
- `rf_rd_addr` out IDX_W: register-file debug read address.
- `rf_rd_data` in DATA_W: read data, valid one cycle after the address is presented.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_tag` out 8: 0x00 cycle, 0x01 PC, 0x02 ALU result, 0x10+i register i.
- `out_data` out DATA_W: stream word.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- `cycle_cnt` (32-bit) resets to 1 and increments by 1 every cycle in IDLE. It holds in all other states and wraps modulo 2^32.
- **IDLE**:
  - Trigger = `dbg_start`, or (`stop_cycle` != 0 and `cycle_cnt` == `stop_cycle`).
  - On trigger: snapshot `cycle_cnt`, `pc_in` and `alu_out_in` into registers, set `halt_req`, and go to HALT.
  - If both trigger sources fire in the same cycle, only one dump runs.
- **HALT**: wait for `halt_ack`; wait is unbounded. On `halt_ack`, go to HDR with word index 0.
- **HDR**:
  - Present `out_valid`=1 with tag/data for snapshot word k (k=0,1,2).
  - Advance k on a handshake (`out_valid` && `out_ready`).
  - After word 2 is accepted, go to RDREQ with reg index r=0.
- **RDREQ**: drive `rf_rd_addr`=r for one cycle, then go to RDCAP.
- **RDCAP**: register `rf_rd_data` into the output holding register, set tag 0x10+r, then go to EMIT.
- **EMIT**:
  - `out_valid`=1; data and tag stay stable until the handshake.
  - On handshake: if r == NUM_REGS-1, go to DONE; else r++ and go to RDREQ.
- **DONE**: `done`=1 for one cycle, `halt_req` drops, return to IDLE. `cycle_cnt` resumes from its held value + 1.
- A dump is exactly 3+NUM_REGS words, in order: cycle, PC, ALU, R0..R(NUM_REGS-1).
- `dbg_start` and `stop_cycle` matches are ignored outside IDLE. A `stop_cycle` value already passed is not re-hit until wrap-around.
- `halt_ack` dropping during a dump is ignored; the dump completes on the captured snapshot.

## Timing
- Reset values:
  - Outputs: `halt_req`=0, `rf_rd_addr`=0, `out_valid`=0, `out_tag`=0, `out_data`=0, `busy`=0, `done`=0.
  - Internal: state IDLE, `cycle_cnt`=1.
- Reset asserted mid-dump aborts it on that edge. All outputs take their reset values the next cycle and no further words are emitted.
- Trigger to `halt_req` high: 1 cycle, registered.
- `halt_ack` to first `out_valid`: 1 cycle.
- With `out_ready` tied high:
  - Header words are 1 per cycle.
  - Each register word takes 3 cycles (RDREQ, RDCAP, EMIT).
  - A full dump with NUM_REGS=32 and `halt_ack` already high occupies 1+1+3+96+1 = 102 cycles from trigger to `done`.
- `out_valid` never deasserts without a handshake. `out_tag`/`out_data` never change while `out_valid`=1 and `out_ready`=0.
- `done` is asserted the cycle after the final handshake. `halt_req` is low starting the cycle after `done`.

## Test plan
- **Auto-trigger**: `stop_cycle`=8, `pc_in`=200 at cycle 8, core regs R0..R3 = 16, 17, 0, 17, `out_ready`=1, `halt_ack` = `halt_req` delayed 1 cycle.
  - Stream: (0x00, 8), (0x01, 200), (0x02, ALU value at cycle 8), (0x10, 16), (0x11, 17), (0x12, 0), (0x13, 17), ...
  - Exactly 35 words, then a single `done` pulse.
- **Backpressure**: toggle `out_ready` 0/1 every cycle during the dump.
  - No word is lost or duplicated.
  - Data/tag stay stable while stalled.
  - Total words = 35.
- **Halt wait**: hold `halt_ack` low for 20 cycles after the trigger.
  - `out_valid` stays 0 and `cycle_cnt` stays frozen.
  - First word appears 1 cycle after `halt_ack` rises.
- **Ignored triggers**: pulse `dbg_start` mid-dump and set `stop_cycle` equal to the held count.
  - Only one dump is emitted.
  - After `done`, the next `dbg_start` produces a cycle word = held count + 1 + idle cycles.
- **Mid-dump reset**: drive `rst_n`=0 after the 10th word.
  - Next cycle: all outputs 0 and state IDLE.
  - After release, `cycle_cnt` restarts at 1 and a new `stop_cycle`=4 dump reports cycle word 4.
- **Disable**: `stop_cycle`=0 with no `dbg_start` for 1000 cycles. `halt_req` and `out_valid` stay 0 throughout.
